blink_tick_gen: RTL

Upstream pacing stage for the blinking LED block. Synchronises and debounces a raw push-button, steps a blink-rate selector on each confirmed press, and emits a one-cycle tick strobe whose period depends on the selected rate. The blinker toggles its LED on each tick, so a button press changes the blink speed.

---
 rtl/blink_tick_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/blink_tick_gen.sv
// Button-driven blink pacing: 2-flop sync, 4-state debounce, rate selector and tick divider.
// Optional LONG_PRESS_RESET_EN: holding the button LONG_PRESS_CYCLES forces rate back to 0.
module blink_tick_gen #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int BASE_DIV          = 8,
  parameter int RATE_W            = 2,
  parameter int LONG_PRESS_CYCLES = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              button,
  input  logic              enable,
  output logic              tick,
  output logic [RATE_W-1:0] rate,
  output logic              pressed
);

  localparam int NUM_RATES = 2**RATE_W;
  localparam int DIV_W     = $clog2(BASE_DIV << (NUM_RATES-1));
  localparam int PER_W     = DIV_W + 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES-1);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} db_state_t;

  logic            s1, s2;
  db_state_t       state, state_nxt;
  logic [DB_W-1:0] db_cnt, db_cnt_nxt;
  logic            accept;
  logic            long_hit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= STABLE_LO;
      db_cnt <= '0;
    end else begin
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Any disagreement with the checked level drops straight back to the stable state.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    accept     = 1'b0;
    case (state)
      STABLE_LO: if (s2) begin
        state_nxt  = CHK_HI;
        db_cnt_nxt = DB_W'(1);
      end
      CHK_HI: begin
        if (!s2) begin
          state_nxt  = STABLE_LO;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = STABLE_HI;
          db_cnt_nxt = '0;
          accept     = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      STABLE_HI: if (!s2) begin
        state_nxt  = CHK_LO;
        db_cnt_nxt = DB_W'(1);
      end
      CHK_LO: begin
        if (s2) begin
          state_nxt  = STABLE_HI;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt  = STABLE_LO;
          db_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_nxt  = STABLE_LO;
        db_cnt_nxt = '0;
      end
    endcase
  end

`ifdef LONG_PRESS_RESET_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt;

  // Saturation at LONG_PRESS_CYCLES makes the hit fire once per press.
  assign long_hit = (state == STABLE_HI) && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES-1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      hold_cnt <= '0;
    else if (state != STABLE_HI)
      hold_cnt <= '0;
    else if (hold_cnt != HOLD_W'(LONG_PRESS_CYCLES))
      hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`else
  assign long_hit = 1'b0;
`endif

  logic [PER_W-1:0] period;
  logic [DIV_W-1:0] div_cnt;
  logic             terminal;

  assign period   = PER_W'(BASE_DIV) << rate;
  assign terminal = ({1'b0, div_cnt} == (period - PER_W'(1)));

  // A rate change restarts the period and wins over a coincident terminal count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rate    <= '0;
      pressed <= 1'b0;
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      pressed <= accept;
      if (long_hit)
        rate <= '0;
      else if (accept)
        rate <= rate + RATE_W'(1);
      if (accept || long_hit || !enable) begin
        div_cnt <= '0;
        tick    <= 1'b0;
      end else if (terminal) begin
        div_cnt <= '0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
        tick    <= 1'b0;
      end
    end
  end

endmodule
